// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cpu_pkg
//  Purpose   : Shared types and helpers for the lab CPU control path:
//              opcode and phase encodings plus the ALU-class opcode test.
//  Revision  : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int CPU_OP_W    = 3;
  localparam int CPU_PHASE_W = 3;

  // Instruction set, in opcode order
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Eight-phase instruction cycle, in execution order
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes that read an operand from memory and write the accumulator
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : cpu_ctrl
//  Purpose   : Phase sequencer and instruction decoder for the lab CPU.
//              Steps a fixed 8-phase cycle per instruction and decodes the
//              IR opcode into memory, IR, accumulator and PC strobes.
//              A HLT instruction freezes the sequencer until rst_.
//  Revision  : 1.0  initial release
// ============================================================================
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int PHASE_W = 3
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            sel,
  output logic            rd,
  output logic            ld_ir,
  output logic            ld_ac,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            wr,
  output logic            data_e,
  output logic            halt
);

  // The encodings in cpu_pkg are 3 bits wide; other widths cannot work.
  if (OP_W != CPU_OP_W) begin : g_bad_op_w
    $error("cpu_ctrl: OP_W must be 3");
  end
  if (PHASE_W != CPU_PHASE_W) begin : g_bad_phase_w
    $error("cpu_ctrl: PHASE_W must be 3");
  end

  phase_t  phase_q;
  phase_t  phase_d;
  logic    halt_q;
  logic    halt_d;
  opcode_t op;
  logic    alu_op;

  // Opcode is only meaningful from OP_ADDR onward; every use below is
  // qualified by one of phases 4..7, so garbage earlier has no effect.
  assign op     = opcode_t'(opcode);
  assign alu_op = is_aluop(op);

  // Phase and halt registers, asynchronously cleared by rst_
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q <= INST_ADDR;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end

  // Next phase: advance and wrap, except HLT leaving OP_ADDR freezes there
  always_comb begin
    phase_d = phase_t'(phase_q + 3'd1);
    halt_d  = halt_q;
    if (halt_q) begin
      phase_d = phase_q;
    end else if ((phase_q == OP_ADDR) && (op == HLT)) begin
      phase_d = OP_ADDR;
      halt_d  = 1'b1;
    end
  end

  // Strobe decode from phase, opcode and zero; halt masks everything else
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halt_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (op != HLT);
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (op == SKZ) && zero;
          ld_pc  = (op == JMP);
          data_e = (op == STO);
        end
        STORE: begin
          // JMP raises both inc_pc and ld_pc; the PC's load priority
          // makes the jump target win.
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = (op == JMP);
          ld_pc  = (op == JMP);
          wr     = (op == STO);
          data_e = (op == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Writes must always have the data bus driven
  a_wr_data_e : assert property (@(posedge clk) disable iff (!rst_)
                                 wr |-> data_e);

  // IR loads only from the PC-addressed instruction fetch
  a_ld_ir_sel : assert property (@(posedge clk) disable iff (!rst_)
                                 ld_ir |-> sel);

  // Outputs are fully known out of reset
  a_no_x : assert property (@(posedge clk) disable iff (!rst_)
                            !$isunknown({sel, rd, ld_ir, ld_ac, inc_pc,
                                         ld_pc, wr, data_e, halt}));
`endif

endmodule : cpu_ctrl
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_cpu_ctrl
//  Purpose   : Self-checking bench for cpu_ctrl with a phase/halt reference
//              model and an attached program counter.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl;

  logic       clk;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         m_phase;
  bit         m_halt;
  logic [4:0] m_pc;

  // Instruction being executed and the zero flag to present
  logic [2:0] cur_op;
  logic       cur_zero;

  // Program counter fed by the strobes: load wins over increment
  localparam logic [4:0] PC_DATA = 5'h1A;
  logic [4:0] pc_count;

  cpu_ctrl #(.OP_W(3), .PHASE_W(3)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)       pc_count <= 5'd0;
    else if (ld_pc)  pc_count <= PC_DATA;
    else if (inc_pc) pc_count <= pc_count + 5'd1;
  end

  // Expected strobes {sel,rd,ld_ir,ld_ac,inc_pc,ld_pc,wr,data_e,halt}
  function automatic logic [8:0] expect_vec(int ph, logic [2:0] op, logic z, bit h);
    logic alu, s, r, li, la, ip, lp, w, de;
    if (h) return 9'b0_0000_0001;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    s   = (ph < 4);
    r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    li  = (ph == 2) || (ph == 3);
    la  = (ph == 7) && alu;
    ip  = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    lp  = (ph >= 6) && (op == 3'd7);
    w   = (ph == 7) && (op == 3'd6);
    de  = (ph >= 6) && (op == 3'd6);
    return {s, r, li, la, ip, lp, w, de, 1'b0};
  endfunction

  task automatic check_vec(input string tag);
    logic [8:0] obs, exp;
    obs = {sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt};
    exp = expect_vec(m_phase, opcode, zero, m_halt);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s phase=%0d op=%b observed=%b expected=%b", tag, m_phase, opcode, obs, exp);
    end
    tests++;
    assert (pc_count === m_pc) else begin
      fails++;
      $error("FAIL %s_pc observed=%h expected=%h", tag, pc_count, m_pc);
    end
  endtask

  // Model of one rising edge, using the inputs held across it
  task automatic model_edge();
    logic [8:0] e;
    e = expect_vec(m_phase, opcode, zero, m_halt);
    if (e[3])      m_pc = PC_DATA;
    else if (e[4]) m_pc = m_pc + 5'd1;
    if (m_halt) begin
      // frozen
    end else if (m_phase == 4 && opcode == 3'd0) begin
      m_halt = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  // Present inputs for the current phase, check, then take one clock
  task automatic step(input string tag);
    if (m_phase < 4) opcode = ($urandom_range(0, 3) == 0) ? 3'bxxx : 3'($urandom);
    else             opcode = cur_op;
    zero = cur_zero;
    #1 check_vec(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_    = 1'b0;
    m_phase = 0;
    m_halt  = 1'b0;
    m_pc    = 5'd0;
    #1 check_vec("reset_assert");
    @(posedge clk);
    #1 check_vec("reset_hold");
    rst_ = 1'b1;
    #1 check_vec("reset_release");
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
    cur_op   = op;
    cur_zero = z;
    repeat (8) step(tag);
  endtask

  // Structural properties checked on every falling edge out of reset
  always @(negedge clk) begin
    if (rst_ === 1'b1) begin
      tests++;
      assert (!(wr === 1'b1) || (data_e === 1'b1)) else begin
        fails++;
        $error("FAIL wr_implies_data_e observed wr=%b data_e=%b expected data_e=1", wr, data_e);
      end
      tests++;
      assert (!(ld_ir === 1'b1) || (sel === 1'b1)) else begin
        fails++;
        $error("FAIL ld_ir_needs_sel observed ld_ir=%b sel=%b expected sel=1", ld_ir, sel);
      end
      tests++;
      assert (!$isunknown({sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt})) else begin
        fails++;
        $error("FAIL outputs_known observed=%b expected no X",
               {sel, rd, ld_ir, ld_ac, inc_pc, ld_pc, wr, data_e, halt});
      end
    end
  end

  initial begin
    logic [4:0] pc_before;
    rst_     = 1'b0;
    opcode   = 3'd0;
    zero     = 1'b0;
    cur_op   = 3'd2;
    cur_zero = 1'b0;
    #3;
    do_reset();

    // ADD, zero=0: full phase walk and wrap back to INST_ADDR
    run_instr(3'd2, 1'b0, "add");
    cur_op = 3'd2;
    step("add_wrap");

    // SKZ with zero=1 advances the PC twice per instruction
    while (m_phase != 0) step("align");
    pc_before = pc_count;
    run_instr(3'd1, 1'b1, "skz_z1");
    tests++;
    assert (pc_count === 5'(pc_before + 5'd2)) else begin
      fails++;
      $error("FAIL skz_skip observed=%h expected=%h", pc_count, 5'(pc_before + 5'd2));
    end
    pc_before = pc_count;
    run_instr(3'd1, 1'b0, "skz_z0");
    tests++;
    assert (pc_count === 5'(pc_before + 5'd1)) else begin
      fails++;
      $error("FAIL skz_noskip observed=%h expected=%h", pc_count, 5'(pc_before + 5'd1));
    end

    // JMP loads the target through the counter's load priority
    run_instr(3'd7, 1'b0, "jmp");
    tests++;
    assert (pc_count === 5'h1A) else begin
      fails++;
      $error("FAIL jmp_target observed=%h expected=%h", pc_count, 5'h1A);
    end

    // STO: data_e in ALU_OP/STORE, wr only in STORE
    run_instr(3'd6, 1'b1, "sto");

    // HLT: halts after OP_ADDR, stays frozen, cleared only by reset
    cur_op   = 3'd0;
    cur_zero = 1'b0;
    repeat (5) step("hlt_enter");
    tests++;
    assert (halt === 1'b1) else begin
      fails++;
      $error("FAIL hlt_set observed=%b expected=1", halt);
    end
    cur_op = 3'd2;
    repeat (20) step("hlt_frozen");
    do_reset();
    run_instr(3'd5, 1'b0, "after_hlt");

    // Asynchronous reset in ALU_OP of a STO
    cur_op   = 3'd6;
    cur_zero = 1'b0;
    while (m_phase != 6) step("sto_pre");
    opcode = 3'd6;
    zero   = 1'b0;
    #1 check_vec("sto_alu");
    tests++;
    assert (data_e === 1'b1) else begin
      fails++;
      $error("FAIL sto_data_e observed=%b expected=1", data_e);
    end
    rst_    = 1'b0;
    m_phase = 0;
    m_halt  = 1'b0;
    m_pc    = 5'd0;
    #1 check_vec("async_rst");
    tests++;
    assert (data_e === 1'b0) else begin
      fails++;
      $error("FAIL async_data_e observed=%b expected=0", data_e);
    end
    @(posedge clk);
    #1 rst_ = 1'b1;
    run_instr(3'd3, 1'b1, "post_async");

    // Randomized instruction stream, including HLT recovered by reset
    for (int n = 0; n < 80; n++) begin
      logic [2:0] rop;
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd0 && ($urandom_range(0, 3) != 0)) rop = 3'd4;
      cur_op = rop;
      for (int k = 0; k < 8; k++) begin
        cur_zero = 1'($urandom);
        step("random");
      end
      if (rop == 3'd0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cpu_ctrl
`default_nettype wire
